// File: rtl/gcd_pkg.sv
// Shared types for the GCD job sequencer: FSM state encoding and the job/result
// records exchanged with producers and consumers at the default operand width.
package gcd_pkg;

  localparam int GCD_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] x;
    logic [GCD_WIDTH-1:0] y;
  } job_t;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] x;
    logic [GCD_WIDTH-1:0] y;
    logic [GCD_WIDTH-1:0] gcd;
    logic                 err;
  } res_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Synchronous job FIFO holding {x, y} operand pairs, with registered occupancy.
// Full/empty derive only from the registered level, so a pop never frees a slot
// for a push in the same cycle and an empty FIFO never bypasses storage.
module gcd_job_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_x,
  input  logic [WIDTH-1:0] push_y,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_x,
  output logic [WIDTH-1:0] pop_y,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign {pop_x, pop_y} = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_x, push_y};
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds queued operand pairs to a GCD core one job at a time, resolves zero
// operands locally, guards against a hung core and holds each result for a consumer.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  output logic                   start,
  output logic [WIDTH-1:0]       x_in,
  output logic [WIDTH-1:0]       y_in,
  input  logic [WIDTH-1:0]       gcd_out,
  input  logic                   gcd_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_x,
  output logic [WIDTH-1:0]       res_y,
  output logic [WIDTH-1:0]       res_gcd,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] job_x_q, job_x_d;
  logic [WIDTH-1:0] job_y_q, job_y_d;
  logic [WIDTH-1:0] res_gcd_q, res_gcd_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;
  logic [WDW-1:0]   wdog_q, wdog_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_x, head_y;

  gcd_job_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (in_valid),
    .push_x (in_x),
    .push_y (in_y),
    .pop    (fifo_pop),
    .pop_x  (head_x),
    .pop_y  (head_y),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign in_ready  = !fifo_full;
  assign start     = start_q;
  assign x_in      = job_x_q;
  assign y_in      = job_y_q;
  assign res_x     = job_x_q;
  assign res_y     = job_y_q;
  assign res_gcd   = res_gcd_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    job_x_d     = job_x_q;
    job_y_d     = job_y_q;
    res_gcd_d   = res_gcd_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    wdog_d      = wdog_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_x_d  = head_x;
          job_y_d  = head_y;
          // A zero operand makes the answer the other operand; the core is skipped.
          if (head_x == '0 || head_y == '0) begin
            res_gcd_d   = head_x | head_y;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            start_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: state_d = ST_ARM;

      // Guard cycle: a done still high from the previous job is not sampled here.
      ST_ARM: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (gcd_done) begin
          res_gcd_d   = gcd_out;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          res_gcd_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      job_x_q     <= '0;
      job_y_q     <= '0;
      res_gcd_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      job_x_q     <= job_x_d;
      job_y_q     <= job_y_d;
      res_gcd_q   <= res_gcd_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      wdog_q      <= wdog_d;
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer: a behavioural GCD core model with
// normal, random, stale-done and hung modes, and a queue-based result reference.
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int TO = 64;

  logic                clk, reset;
  logic                in_valid, in_ready;
  logic [W-1:0]        in_x, in_y;
  logic                start;
  logic [W-1:0]        x_in, y_in, gcd_out;
  logic                gcd_done;
  logic                res_valid, res_ready;
  logic [W-1:0]        res_x, res_y, res_gcd;
  logic                res_err, busy;
  logic [$clog2(D):0]  level;

  int   cyc;
  int   checks, passed;
  int   start_cnt, last_start_cyc, last_rv_cyc;
  int   core_mode;   // 0 fixed delay, 1 random delay, 2 stale done, 3 hung
  int   core_delay;
  int   core_g;
  res_t exp_q[$];
  res_t got_q[$];

  gcd_job_sequencer #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .gcd_out   (gcd_out),
    .gcd_done  (gcd_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_gcd   (res_gcd),
    .res_err   (res_err),
    .busy      (busy),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic res_t model(input int x, input int y);
    res_t r;
    r.x = W'(x);
    r.y = W'(y);
    if (x == 0 || y == 0) begin
      r.gcd = W'(x | y);
      r.err = 1'b0;
    end else if (core_mode == 3) begin
      r.gcd = '0;
      r.err = 1'b1;
    end else begin
      r.gcd = W'(ref_gcd(x, y));
      r.err = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Samples between the falling and the next rising edge, after inputs have settled.
  initial begin
    logic prev_rv;
    res_t r;
    prev_rv   = 1'b0;
    start_cnt = 0;
    last_start_cyc = -1;
    last_rv_cyc    = -1;
    forever begin
      @(negedge clk);
      #2;
      if (start === 1'b1) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (res_valid === 1'b1 && prev_rv !== 1'b1) last_rv_cyc = cyc;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        r.x   = res_x;
        r.y   = res_y;
        r.gcd = res_gcd;
        r.err = res_err;
        got_q.push_back(r);
      end
      prev_rv = res_valid;
    end
  end

  task automatic pulse_done(input int d, input int g);
    repeat (d) @(negedge clk);
    gcd_out  = W'(g);
    gcd_done = 1'b1;
    @(negedge clk);
    gcd_done = 1'b0;
  endtask

  // Behavioural GCD core: reacts to start according to core_mode.
  initial begin
    gcd_done = 1'b0;
    gcd_out  = '0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        core_g = ref_gcd(32'(x_in), 32'(y_in));
        case (core_mode)
          0: pulse_done(core_delay, core_g);
          1: pulse_done(int'($urandom_range(2, 7)), core_g);
          2: begin
            gcd_done = 1'b1;
            gcd_out  = 4'hF;
            @(negedge clk);
            @(negedge clk);
            gcd_done = 1'b0;
            pulse_done(3, core_g);
          end
          default: ;
        endcase
      end
    end
  end

  // Called on a falling edge; offers one job for one cycle.
  task automatic push(input int x, input int y, output bit acc, output int pc);
    in_valid = 1'b1;
    in_x     = W'(x);
    in_y     = W'(y);
    acc      = in_ready;
    pc       = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    if (acc) exp_q.push_back(model(x, y));
  endtask

  task automatic push_retry(input int x, input int y, input int budget, input bit rnd, output int pc);
    bit acc;
    acc = 1'b0;
    pc  = -1;
    for (int i = 0; i < budget && !acc; i++) begin
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      push(x, y, acc, pc);
    end
    check("push_accepted", 32'(acc), 1);
  endtask

  task automatic wait_results(input int n, input int budget, input bit rnd);
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    res_ready = 1'b1;
    check("result_count", got_q.size(), n);
  endtask

  task automatic compare_all(input string tag);
    res_t g, e;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ".x"},   32'(g.x),   32'(e.x));
      check({tag, ".y"},   32'(g.y),   32'(e.y));
      check({tag, ".gcd"}, 32'(g.gcd), 32'(e.gcd));
      check({tag, ".err"}, 32'(g.err), 32'(e.err));
    end
    check({tag, ".leftover"}, got_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int pc, s0, nacc, refused;
    int jx[6] = '{12, 9, 7, 10, 15, 8};
    int jy[6] = '{8, 3, 5, 4, 5, 6};

    checks = 0;
    passed = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    res_ready = 1'b1;
    core_mode = 0;
    core_delay = 5;

    repeat (3) @(negedge clk);
    check("rst.in_ready",  32'(in_ready), 1);
    check("rst.start",     32'(start), 0);
    check("rst.x_in",      32'(x_in), 0);
    check("rst.y_in",      32'(y_in), 0);
    check("rst.res_valid", 32'(res_valid), 0);
    check("rst.res_x",     32'(res_x), 0);
    check("rst.res_gcd",   32'(res_gcd), 0);
    check("rst.res_err",   32'(res_err), 0);
    check("rst.busy",      32'(busy), 0);
    check("rst.level",     32'(level), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic job through the core
    s0 = start_cnt;
    push(14, 6, acc, pc);
    wait_results(1, 100, 1'b0);
    check("t1.start_count", start_cnt - s0, 1);
    check("t1.start_cycle", last_start_cyc, pc + 2);
    check("t1.rv_cycle",    last_rv_cyc, pc + 8);
    compare_all("t1");
    check("t1.x_in_kept", 32'(x_in), 14);
    check("t1.y_in_kept", 32'(y_in), 6);
    check("t1.busy_idle", 32'(busy), 0);

    // Zero operands resolved locally
    s0 = start_cnt;
    push(0, 9, acc, pc);
    wait_results(1, 50, 1'b0);
    check("t2a.rv_cycle", last_rv_cyc, pc + 2);
    compare_all("t2a");
    push(0, 0, acc, pc);
    wait_results(1, 50, 1'b0);
    check("t2b.rv_cycle", last_rv_cyc, pc + 2);
    compare_all("t2b");
    check("t2.no_start", start_cnt - s0, 0);

    // Backpressure: consumer stalled, six back-to-back offers
    res_ready = 1'b0;
    core_delay = 3;
    nacc = 0;
    refused = -1;
    for (int i = 0; i < 6; i++) begin
      push(jx[i], jy[i], acc, pc);
      if (acc) nacc++;
      else if (refused < 0) refused = i;
    end
    check("t3.accepted", nacc, 5);
    check("t3.refused_idx", refused, 5);
    check("t3.level_full", 32'(level), 4);
    check("t3.in_ready_low", 32'(in_ready), 0);
    repeat (20) @(negedge clk);
    check("t3.held_valid", 32'(res_valid), 1);
    check("t3.held_gcd", 32'(res_gcd), 4);
    check("t3.held_x", 32'(res_x), 12);
    res_ready = 1'b1;
    push_retry(jx[5], jy[5], 100, 1'b0, pc);
    wait_results(6, 400, 1'b0);
    compare_all("t3");

    // Randomized jobs with random core latency and random consumer stalls
    core_mode = 1;
    for (int i = 0; i < 16; i++) begin
      push_retry(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 200, 1'b1, pc);
    end
    wait_results(16, 2000, 1'b1);
    compare_all("t4");

    // Stale done overlapping ISSUE/ARM must be ignored
    core_mode = 2;
    s0 = start_cnt;
    push(9, 6, acc, pc);
    wait_results(1, 100, 1'b0);
    check("t5.start_count", start_cnt - s0, 1);
    compare_all("t5");

    // Hung core: watchdog abort, then a normal job
    core_mode = 3;
    push(8, 4, acc, pc);
    wait_results(1, 200, 1'b0);
    check("t6.rv_cycle", last_rv_cyc, pc + 4 + TO);
    compare_all("t6a");
    core_mode = 0;
    core_delay = 5;
    push(8, 4, acc, pc);
    wait_results(1, 100, 1'b0);
    compare_all("t6b");

    // Reset while WAITing with two jobs queued
    core_mode = 3;
    s0 = start_cnt;
    push(5, 3, acc, pc);
    push(6, 4, acc, pc);
    push(7, 7, acc, pc);
    repeat (8) @(negedge clk);
    check("t7.level_pre", 32'(level), 2);
    check("t7.busy_pre", 32'(busy), 1);
    check("t7.start_pre", start_cnt - s0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t7.level", 32'(level), 0);
    check("t7.in_ready", 32'(in_ready), 1);
    check("t7.busy", 32'(busy), 0);
    check("t7.start", 32'(start), 0);
    check("t7.res_valid", 32'(res_valid), 0);
    check("t7.x_in", 32'(x_in), 0);
    check("t7.res_err", 32'(res_err), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    check("t7.no_start", start_cnt - s0, 0);
    check("t7.idle_busy", 32'(busy), 0);
    check("t7.no_result", got_q.size(), 0);

    core_mode = 0;
    push(15, 10, acc, pc);
    wait_results(1, 100, 1'b0);
    compare_all("t7post");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream feeder for the GCD core (start / x_in / y_in / gcd_out / gcd_done interface).
- Buffers operand pairs from a valid/ready producer (switch/UART front end) in a small FIFO.
- Issues one single-cycle start per job, waits for gcd_done and captures gcd_out.
- Presents {x, y, gcd, err} to a valid/ready consumer. Zero operands are resolved locally; a watchdog covers a hung core.

Parameters:
- WIDTH, 4, operand/result width; must match the core.
- DEPTH, 4, job FIFO depth; power of two, at least 2.
- TIMEOUT, 64, maximum cycles in WAIT before the job is aborted with err=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  producer has a job.
- in_ready  out  1  FIFO not full.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- start  out  1  one-cycle pulse to the core.
- x_in  out  WIDTH  operand x to the core; held stable from ISSUE through WAIT.
- y_in  out  WIDTH  operand y to the core; held stable from ISSUE through WAIT.
- gcd_out  in  WIDTH  core result.
- gcd_done  in  1  core result valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_x  out  WIDTH  job x echo.
- res_y  out  WIDTH  job y echo.
- res_gcd  out  WIDTH  result.
- res_err  out  1  watchdog abort.
- busy  out  1  state != IDLE, or FIFO non-empty.
- level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: in_ready=1, start=0, x_in=y_in=0, res_valid=0, res_x=res_y=res_gcd=0, res_err=0, busy=0, level=0. State=IDLE; FIFO pointers=0; watchdog=0.
- FIFO
  - Push when in_valid && in_ready.
  - Pop only in IDLE, when non-empty.
  - Push and pop in the same cycle with FIFO full: push refused, because in_ready depends only on registered level.
  - Push and pop in the same cycle with FIFO empty: no bypass; the job goes through storage.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, ARM, WAIT, HOLD.
- IDLE
  - If FIFO is empty, stay in IDLE.
  - Otherwise pop the head into the job registers (x_in, y_in, res_x, res_y).
  - If x==0 or y==0: res_gcd = x|y (0,0 gives 0), res_err=0, go to HOLD. No start is issued.
  - Otherwise go to ISSUE.
- ISSUE: start=1 for exactly this cycle; go to ARM.
- ARM
  - One guard cycle; gcd_done is ignored here, so a stale done from the previous job is not accepted.
  - Clear the watchdog; go to WAIT.
- WAIT
  - If gcd_done=1: res_gcd <= gcd_out, res_err <= 0, go to HOLD.
  - Else if watchdog == TIMEOUT-1: res_gcd <= 0, res_err <= 1, go to HOLD.
  - Else increment the watchdog.
- HOLD
  - res_valid=1; outputs stay stable while res_ready=0.
  - When res_ready=1, transfer completes; go to IDLE.
  - Next pop happens in the following cycle. Minimum job-to-job spacing is one IDLE cycle.
- Latency
  - Pop to start: 1 cycle.
  - gcd_done to res_valid: 1 cycle.
  - Zero-operand job, pop to res_valid: 1 cycle.
- x_in/y_in retain the last job's values after completion; they do not return to 0.
- Reset mid-job: start deasserts immediately; the FIFO is emptied and any held result is discarded. The core shares the same reset.
- All arithmetic is unsigned WIDTH-bit. level counts 0..DEPTH inclusive.

Decomposition:
- Shared package gcd_pkg:
  - WIDTH default.
  - FSM state enum {IDLE, ISSUE, ARM, WAIT, HOLD}.
  - Job record typedef {x, y}.
  - Result record typedef {x, y, gcd, err}.
- One sub-module: gcd_job_fifo (synchronous FIFO, DEPTH x 2*WIDTH, with full/empty/level and async reset). The FSM and watchdog stay in the top.

Test Plan:
- Push (14,6) with res_ready=1 and a core model returning done 5 cycles after start:
  - start pulses exactly once, one cycle after pop.
  - res_gcd=2, res_x=14, res_y=6, res_err=0.
- Push (0,9), then (0,0):
  - No start pulse for either job.
  - Results are 9 and 0; each appears one cycle after its pop.
- Hold res_ready=0, push 6 jobs back-to-back (DEPTH=4):
  - in_ready drops after 5 accepted (4 queued plus 1 in flight).
  - level=4.
  - Results drain in order: (12,8)->4, (9,3)->3, (7,5)->1, …
- Core model leaves gcd_done high from the previous job, then pulses it late:
  - The stale done is ignored in ARM.
  - The correct new result is captured.
- Core model never asserts gcd_done (TIMEOUT=64):
  - res_valid rises 64 cycles after entering WAIT, with res_err=1 and res_gcd=0.
  - The next job proceeds normally.
- Assert reset during WAIT with 2 jobs queued:
  - All outputs return to reset values asynchronously; level=0.
  - After release, no start is issued until a new push.
